// File: rtl/uart_pkg.sv
// Shared constants and state types for the Wishbone UART.
package uart_pkg;

  // Register offsets within the 16-byte window (adr[3:0])
  localparam logic [3:0] REG_TXDATA   = 4'h0;
  localparam logic [3:0] REG_RXDATA   = 4'h4;
  localparam logic [3:0] REG_STATUS   = 4'h8;
  localparam logic [3:0] REG_BAUD_DIV = 4'hC;

  // STATUS register bit positions
  localparam int STAT_TX_FULL      = 0;
  localparam int STAT_TX_EMPTY     = 1;
  localparam int STAT_TX_BUSY      = 2;
  localparam int STAT_RX_VALID     = 3;
  localparam int STAT_RX_OVERRUN   = 4;
  localparam int STAT_RX_FRAME_ERR = 5;

  // Smallest divisor that still gives the receiver a usable mid-bit sample
  localparam logic [15:0] BAUD_DIV_MIN = 16'd3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Raise a requested divisor to the supported minimum
  function automatic logic [15:0] clamp_baud(input logic [15:0] value);
    if (value < BAUD_DIV_MIN) begin
      clamp_baud = BAUD_DIV_MIN;
    end else begin
      clamp_baud = value;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign pop_data = mem_r[rd_ptr_r[AW-1:0]];

  // Advance pointers; pushes into a full FIFO and pops from an empty one are dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk_i) begin
    if (push && !full) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/wb_uart.sv
// Wishbone B4 classic slave UART: 8N1 transmit via FIFO, receive into a holding register.
module wb_uart
  import uart_pkg::*;
#(
  parameter int WISHBONE_ADDR_WIDTH = 32,
  parameter int WISHBONE_BUS_WIDTH  = 32,
  parameter int TX_FIFO_DEPTH       = 4,
  parameter int DEFAULT_BAUD_DIV    = 867
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wbs_cyc,
  input  logic                            wbs_stb,
  input  logic [WISHBONE_ADDR_WIDTH-1:0]  wbs_adr,
  input  logic                            wbs_we,
  input  logic [WISHBONE_BUS_WIDTH-1:0]   wbs_dat_i,
  input  logic [WISHBONE_BUS_WIDTH/8-1:0] wbs_sel,
  output logic [WISHBONE_BUS_WIDTH-1:0]   wbs_dat_o,
  output logic                            wbs_ack,
  output logic                            wbs_err,
  output logic                            uart_tx,
  input  logic                            uart_rx
);

  localparam logic [15:0] BAUD_RST = 16'(DEFAULT_BAUD_DIV);

  // Bus response and configuration registers
  logic                          ack_r, err_r;
  logic [WISHBONE_BUS_WIDTH-1:0] dat_r;
  logic [15:0]                   baud_r;
  // TX datapath
  tx_state_t   tx_state_r;
  logic [15:0] tx_cnt_r, tx_div_r;
  logic [7:0]  tx_shift_r;
  logic [2:0]  tx_bit_r;
  logic        uart_tx_r;
  // RX datapath
  rx_state_t   rx_state_r;
  logic        rx_meta_r, rx_sync_r, rx_prev_r;
  logic [15:0] rx_cnt_r, rx_div_r, rx_half_r;
  logic [7:0]  rx_shift_r, rx_byte_r;
  logic [2:0]  rx_bit_r;
  logic        rx_valid_r, rx_overrun_r, rx_frame_err_r;

  logic [3:0]  off_s;
  logic        req_s, bad_adr_s, err_s, ok_s;
  logic        wr_tx_s, rd_rx_s, wr_stat_s, wr_baud_s;
  logic        fifo_full_s, fifo_empty_s, fifo_pop_s, tx_busy_s, rx_done_s;
  logic [7:0]  fifo_dout_s;
  logic [5:0]  status_s;
  logic [15:0] baud_wr_s, rx_half_s;
  logic [16:0] baud_p1_s;
  logic [WISHBONE_BUS_WIDTH-1:0] rd_data_s;
  logic        unused_s;

  assign wbs_ack   = ack_r;
  assign wbs_err   = err_r;
  assign wbs_dat_o = dat_r;
  assign uart_tx   = uart_tx_r;
  assign unused_s  = ^{wbs_adr[WISHBONE_ADDR_WIDTH-1:16], wbs_dat_i[WISHBONE_BUS_WIDTH-1:16],
                       wbs_sel[WISHBONE_BUS_WIDTH/8-1:2]};

  // Decode the request and the access strobes; errored requests produce no strobes
  always_comb begin
    off_s     = wbs_adr[3:0];
    req_s     = wbs_cyc & wbs_stb & ~(ack_r | err_r);
    bad_adr_s = (wbs_adr[1:0] != 2'b00) || (wbs_adr[15:4] != 12'h000);
    err_s     = bad_adr_s || (wbs_we && (off_s == REG_TXDATA) && fifo_full_s);
    ok_s      = req_s & ~err_s;
    wr_tx_s   = ok_s & wbs_we & (off_s == REG_TXDATA) & wbs_sel[0];
    rd_rx_s   = ok_s & ~wbs_we & (off_s == REG_RXDATA);
    wr_stat_s = ok_s & wbs_we & (off_s == REG_STATUS) & wbs_sel[0];
    wr_baud_s = ok_s & wbs_we & (off_s == REG_BAUD_DIV);
  end

  // Assemble STATUS, the byte-lane-merged divisor and the RX half-bit delay
  always_comb begin
    status_s                    = 6'd0;
    status_s[STAT_TX_FULL]      = fifo_full_s;
    status_s[STAT_TX_EMPTY]     = fifo_empty_s;
    status_s[STAT_TX_BUSY]      = tx_busy_s;
    status_s[STAT_RX_VALID]     = rx_valid_r;
    status_s[STAT_RX_OVERRUN]   = rx_overrun_r;
    status_s[STAT_RX_FRAME_ERR] = rx_frame_err_r;
    if (wbs_sel[0]) begin
      baud_wr_s[7:0] = wbs_dat_i[7:0];
    end else begin
      baud_wr_s[7:0] = baud_r[7:0];
    end
    if (wbs_sel[1]) begin
      baud_wr_s[15:8] = wbs_dat_i[15:8];
    end else begin
      baud_wr_s[15:8] = baud_r[15:8];
    end
    // START lasts (div+1)/2 cycles, so the sample falls on count (div+1)/2-1
    baud_p1_s = {1'b0, baud_r} + 17'd1;
    rx_half_s = baud_p1_s[16:1] - 16'd1;
  end

  // Read-data multiplexer
  always_comb begin
    rd_data_s = {WISHBONE_BUS_WIDTH{1'b0}};
    case (off_s)
      REG_RXDATA:   rd_data_s[8:0]  = {rx_valid_r, rx_byte_r};
      REG_STATUS:   rd_data_s[5:0]  = status_s;
      REG_BAUD_DIV: rd_data_s[15:0] = baud_r;
      default:      rd_data_s       = {WISHBONE_BUS_WIDTH{1'b0}};
    endcase
  end

  // One-cycle ack/err response; read data only accompanies an ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      dat_r <= {WISHBONE_BUS_WIDTH{1'b0}};
    end else begin
      ack_r <= ok_s;
      err_r <= req_s & err_s;
      dat_r <= (ok_s && !wbs_we) ? rd_data_s : {WISHBONE_BUS_WIDTH{1'b0}};
    end
  end

  // Baud divisor register with lane writes and minimum clamp
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_r <= BAUD_RST;
    end else if (wr_baud_s) begin
      baud_r <= clamp_baud(baud_wr_s);
    end
  end

  sync_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (wr_tx_s),
    .push_data (wbs_dat_i[7:0]),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_dout_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign tx_busy_s  = (tx_state_r != TX_IDLE);
  assign fifo_pop_s = !fifo_empty_s &&
                      ((tx_state_r == TX_IDLE) || ((tx_state_r == TX_STOP) && (tx_cnt_r == tx_div_r)));

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit, chaining frames without a gap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_div_r   <= 16'd0;
      tx_shift_r <= 8'd0;
      tx_bit_r   <= 3'd0;
      uart_tx_r  <= 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          tx_cnt_r <= 16'd0;
          if (!fifo_empty_s) begin
            tx_shift_r <= fifo_dout_s;
            tx_div_r   <= baud_r;
            tx_state_r <= TX_START;
            uart_tx_r  <= 1'b0;
          end else begin
            uart_tx_r  <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt_r == tx_div_r) begin
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            uart_tx_r  <= tx_shift_r[0];
            tx_state_r <= TX_DATA;
          end else begin
            tx_cnt_r   <= tx_cnt_r + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_r == tx_div_r) begin
            tx_cnt_r <= 16'd0;
            if (tx_bit_r == 3'd7) begin
              tx_state_r <= TX_STOP;
              uart_tx_r  <= 1'b1;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              uart_tx_r  <= tx_shift_r[tx_bit_r + 3'd1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_r == tx_div_r) begin
            tx_cnt_r <= 16'd0;
            if (!fifo_empty_s) begin
              tx_shift_r <= fifo_dout_s;
              tx_div_r   <= baud_r;
              tx_state_r <= TX_START;
              uart_tx_r  <= 1'b0;
            end else begin
              tx_state_r <= TX_IDLE;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          uart_tx_r  <= 1'b1;
        end
      endcase
    end
  end

  assign rx_done_s = (rx_state_r == RX_STOP) && (rx_cnt_r == rx_div_r);

  // Receive FSM behind a 2-FF synchronizer, triggered by a falling edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_div_r   <= 16'd0;
      rx_half_r  <= 16'd0;
      rx_shift_r <= 8'd0;
      rx_bit_r   <= 3'd0;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= 16'd0;
          if (rx_prev_r && !rx_sync_r) begin
            rx_state_r <= RX_START;
            rx_div_r   <= baud_r;
            rx_half_r  <= rx_half_s;
          end
        end
        RX_START: begin
          if (rx_cnt_r == rx_half_r) begin
            rx_cnt_r <= 16'd0;
            rx_bit_r <= 3'd0;
            // A line already back high was a glitch, not a start bit
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == rx_div_r) begin
            rx_cnt_r   <= 16'd0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              rx_bit_r   <= rx_bit_r + 3'd1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == rx_div_r) begin
            rx_cnt_r   <= 16'd0;
            rx_state_r <= RX_IDLE;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Holding register and sticky flags; a flag set wins over a same-cycle W1C
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_byte_r      <= 8'd0;
      rx_valid_r     <= 1'b0;
      rx_overrun_r   <= 1'b0;
      rx_frame_err_r <= 1'b0;
    end else begin
      if (wr_stat_s && wbs_dat_i[STAT_RX_OVERRUN]) begin
        rx_overrun_r <= 1'b0;
      end
      if (wr_stat_s && wbs_dat_i[STAT_RX_FRAME_ERR]) begin
        rx_frame_err_r <= 1'b0;
      end
      if (rx_done_s && rx_sync_r) begin
        if (!rx_valid_r || rd_rx_s) begin
          rx_byte_r  <= rx_shift_r;
          rx_valid_r <= 1'b1;
        end else begin
          rx_overrun_r <= 1'b1;
        end
      end else if (rx_done_s) begin
        rx_frame_err_r <= 1'b1;
        if (rd_rx_s) begin
          rx_valid_r <= 1'b0;
        end
      end else if (rd_rx_s) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_uart.sv
// Directed self-checking bench for wb_uart.
module tb_wb_uart;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [31:0] wbs_adr, wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel;
  logic        wbs_ack, wbs_err;
  logic        uart_tx, uart_rx;

  int checks = 0;
  int errors = 0;

  logic rec_on = 1'b0;
  logic tx_q[$];

  wb_uart dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wbs_cyc   (wbs_cyc),
    .wbs_stb   (wbs_stb),
    .wbs_adr   (wbs_adr),
    .wbs_we    (wbs_we),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel   (wbs_sel),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack   (wbs_ack),
    .wbs_err   (wbs_err),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx)
  );

  always #5 clk_i = ~clk_i;

  // Record the serial line once per cycle, mid-cycle
  always @(negedge clk_i) begin
    if (rec_on) tx_q.push_back(uart_tx);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // One classic-cycle access; response sampled one cycle after the request
  task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                     input logic [3:0] sel, output logic ack, output logic err,
                     output logic [31:0] rdat);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_adr = adr; wbs_we = we;
    wbs_dat_i = dat; wbs_sel = sel;
    @(posedge clk_i);
    #1;
    ack = wbs_ack; err = wbs_err; rdat = wbs_dat_o;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  // Drive one 8N1 frame at 4 cycles per bit, then idle
  task automatic send_rx(input logic [7:0] d, input logic stop);
    uart_rx = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(4);
    end
    uart_rx = stop;
    tick(4);
    uart_rx = 1'b1;
    tick(8);
  endtask

  task automatic test_reset;
    logic a, e; logic [31:0] r;
    rst_i = 1'b1;
    tick(3);
    checks++; if (wbs_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", wbs_ack); end
    checks++; if (wbs_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", wbs_err); end
    checks++; if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h expected 0", wbs_dat_o); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", uart_tx); end
    rst_i = 1'b0;
    tick(2);
    checks++; if (wbs_ack !== 1'b0) begin errors++; $display("FAIL idle_ack: got %b expected 0", wbs_ack); end
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL status_ack: got ack=%b err=%b expected 1/0", a, e); end
    checks++; if (r !== 32'h0000_0002) begin errors++; $display("FAIL status_rst: got %h expected 00000002", r); end
    bus(BASE + 32'hC, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'd867) begin errors++; $display("FAIL baud_rst: got %0d expected 867", r); end
    bus(BASE + 32'h0, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (a !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL txdata_rd: got ack=%b dat=%h expected 1/0", a, r); end
  endtask

  task automatic test_tx_frame;
    logic a, e; logic [31:0] r; int k; int bp; logic exp_b; logic [7:0] d;
    d = 8'h55;
    bus(BASE + 32'hC, 1'b1, 32'h3, 4'h3, a, e, r);
    bus(BASE + 32'hC, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL baud_wr: got %h expected 3", r); end
    tx_q.delete();
    rec_on = 1'b1;
    bus(BASE + 32'h0, 1'b1, {24'h0, d}, 4'h1, a, e, r);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL tx_push_ack: got ack=%b err=%b expected 1/0", a, e); end
    tick(50);
    rec_on = 1'b0;
    k = -1;
    for (int i = 0; i < tx_q.size(); i++) if (k < 0 && tx_q[i] == 1'b0) k = i;
    checks++;
    if (k < 0 || k + 44 > tx_q.size()) begin
      errors++; $display("FAIL tx_frame_start: start bit not seen (k=%0d size=%0d)", k, tx_q.size());
    end else begin
      for (int i = 0; i < 44; i++) begin
        bp = i / 4;
        if (bp == 0) exp_b = 1'b0;
        else if (bp <= 8) exp_b = d[bp-1];
        else exp_b = 1'b1;
        checks++;
        if (tx_q[k+i] !== exp_b) begin errors++; $display("FAIL tx_frame_55: sample %0d got %b expected %b", i, tx_q[k+i], exp_b); end
      end
    end
    bus(BASE + 32'h0, 1'b1, 32'h5A, 4'h1, a, e, r);
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h6) begin errors++; $display("FAIL tx_busy: got %h expected 00000006", r); end
    tick(50);
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL tx_done_status: got %h expected 00000002", r); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_idle: got %b expected 1", uart_tx); end
  endtask

  task automatic test_back_to_back;
    logic a, e; logic [31:0] r; int k; int f; int bp; logic exp_b; logic [7:0] d;
    tx_q.delete();
    rec_on = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      bus(BASE + 32'h0, 1'b1, b, 4'h1, a, e, r);
      checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL b2b_push%0d: got ack=%b err=%b expected 1/0", b, a, e); end
    end
    bus(BASE + 32'h0, 1'b1, 32'h66, 4'h1, a, e, r);
    checks++; if (a !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL b2b_full_err: got ack=%b err=%b expected 0/1", a, e); end
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h5) begin errors++; $display("FAIL b2b_status: got %h expected 00000005", r); end
    tick(220);
    rec_on = 1'b0;
    k = -1;
    for (int i = 0; i < tx_q.size(); i++) if (k < 0 && tx_q[i] == 1'b0) k = i;
    checks++;
    if (k < 0 || k + 204 > tx_q.size()) begin
      errors++; $display("FAIL b2b_start: start bit not seen (k=%0d size=%0d)", k, tx_q.size());
    end else begin
      for (int i = 0; i < 204; i++) begin
        f = i / 40; bp = (i % 40) / 4; d = 8'(f + 1);
        if (f >= 5) exp_b = 1'b1;
        else if (bp == 0) exp_b = 1'b0;
        else if (bp <= 8) exp_b = d[bp-1];
        else exp_b = 1'b1;
        checks++;
        if (tx_q[k+i] !== exp_b) begin errors++; $display("FAIL b2b_stream: sample %0d got %b expected %b", i, tx_q[k+i], exp_b); end
      end
    end
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL b2b_drained: got %h expected 00000002", r); end
  endtask

  task automatic test_rx;
    logic a, e; logic [31:0] r;
    send_rx(8'hA3, 1'b1);
    bus(BASE + 32'h4, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h0000_01A3) begin errors++; $display("FAIL rx_first: got %h expected 000001a3", r); end
    bus(BASE + 32'h4, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h0000_00A3) begin errors++; $display("FAIL rx_second: got %h expected 000000a3", r); end
  endtask

  task automatic test_overrun;
    logic a, e; logic [31:0] r;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h1A) begin errors++; $display("FAIL ovr_status: got %h expected 0000001a", r); end
    bus(BASE + 32'h4, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h111) begin errors++; $display("FAIL ovr_keep_old: got %h expected 00000111", r); end
    bus(BASE + 32'h8, 1'b1, 32'h10, 4'h1, a, e, r);
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL ovr_w1c: got %h expected 00000002", r); end
  endtask

  task automatic test_errors;
    logic a, e; logic [31:0] r;
    send_rx(8'h3C, 1'b1);
    bus(BASE + 32'h2, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (a !== 1'b0 || e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL err_misalign: got ack=%b err=%b dat=%h expected 0/1/0", a, e, r); end
    bus(BASE + 32'h10, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (a !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL err_range: got ack=%b err=%b expected 0/1", a, e); end
    bus(BASE + 32'h14, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (a !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL err_rx_alias: got ack=%b err=%b expected 0/1", a, e); end
    bus(BASE + 32'hE, 1'b1, 32'h0000_0040, 4'hF, a, e, r);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_baud_wr: got err=%b expected 1", e); end
    bus(BASE + 32'hC, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL err_no_baud_change: got %h expected 3", r); end
    bus(BASE + 32'h4, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h13C) begin errors++; $display("FAIL err_no_pop: got %h expected 0000013c", r); end
    send_rx(8'h77, 1'b0);
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h22) begin errors++; $display("FAIL frame_err: got %h expected 00000022", r); end
    bus(BASE + 32'h8, 1'b1, 32'h20, 4'h1, a, e, r);
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL frame_w1c: got %h expected 00000002", r); end
  endtask

  task automatic test_baud_clamp;
    logic a, e; logic [31:0] r;
    bus(BASE + 32'hC, 1'b1, 32'h1, 4'h3, a, e, r);
    bus(BASE + 32'hC, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL baud_clamp: got %h expected 3", r); end
    bus(BASE + 32'hC, 1'b1, 32'hABCD_1234, 4'h2, a, e, r);
    bus(BASE + 32'hC, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h1203) begin errors++; $display("FAIL baud_lane1: got %h expected 00001203", r); end
    bus(BASE + 32'hC, 1'b1, 32'h0000_00FF, 4'h1, a, e, r);
    bus(BASE + 32'hC, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h12FF) begin errors++; $display("FAIL baud_lane0: got %h expected 000012ff", r); end
    bus(BASE + 32'hC, 1'b1, 32'h3, 4'h3, a, e, r);
  endtask

  task automatic test_reset_mid;
    logic a, e; logic [31:0] r; logic stayed_high;
    bus(BASE + 32'h0, 1'b1, 32'h00, 4'h1, a, e, r);
    bus(BASE + 32'h0, 1'b1, 32'hF0, 4'h1, a, e, r);
    bus(BASE + 32'h0, 1'b1, 32'h0F, 4'h1, a, e, r);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_frame_low: got %b expected 0", uart_tx); end
    rst_i = 1'b1;
    tick(1);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_rst_tx: got %b expected 1", uart_tx); end
    rst_i = 1'b0;
    stayed_high = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (uart_tx !== 1'b1) stayed_high = 1'b0;
    end
    checks++; if (stayed_high !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got %b expected 1", stayed_high); end
    bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL mid_rst_status: got %h expected 00000002", r); end
    bus(BASE + 32'hC, 1'b0, 32'h0, 4'hF, a, e, r);
    checks++; if (r !== 32'd867) begin errors++; $display("FAIL mid_rst_baud: got %0d expected 867", r); end
  endtask

  initial begin
    rst_i = 1'b1; wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    wbs_adr = 32'h0; wbs_dat_i = 32'h0; wbs_sel = 4'h0; uart_rx = 1'b1;
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_errors();
    test_baud_clamp();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
